// File: rtl/pds_power_manager.sv
// Power-sourcing port manager: staggered power-up of detected ports under a shared budget,
// with drop on request/loss of detect and lowest-priority shedding when over budget.
module pds_power_manager #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_PWR  = 15,
    parameter int ON_GAP    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             det,
    input  logic [NUM_PORTS-1:0]             off,
    input  logic [2*NUM_PORTS-1:0]           prio,
    input  logic [7:0]                       pwr_bdj,
    input  logic                             ports_off,
    output logic [NUM_PORTS-1:0]             on,
    output logic [8+$clog2(NUM_PORTS+1)-1:0] pwr_used
);

    localparam int CW = $clog2(NUM_PORTS + 1);
    localparam int UW = 8 + CW;
    localparam int UX = UW + 1;
    localparam int GW = (ON_GAP > 2) ? $clog2(ON_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(ON_GAP - 1);
    localparam logic [UW-1:0] PWR_UNIT = UW'(PORT_PWR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SHED   = 2'd2
    } state_t;

    function automatic logic [CW-1:0] popcount(input logic [NUM_PORTS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [UW-1:0] port_power(input logic [NUM_PORTS-1:0] v);
        return UW'(popcount(v)) * PWR_UNIT;
    endfunction

    // Lowest priority wins the shed; ascending scan with <= leaves the highest index on a tie.
    function automatic logic [NUM_PORTS-1:0] pick_victim(input logic [NUM_PORTS-1:0] m,
                                                         input logic [2*NUM_PORTS-1:0] p);
        logic [NUM_PORTS-1:0] sel;
        logic [1:0]           best;
        logic                 found;
        sel   = '0;
        best  = 2'd3;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (m[i] && (!found || (p[2*i +: 2] <= best))) begin
                sel    = '0;
                sel[i] = 1'b1;
                best   = p[2*i +: 2];
                found  = 1'b1;
            end
        end
        return sel;
    endfunction

    // Highest priority wins the grant; descending scan with >= leaves the lowest index on a tie.
    function automatic logic [NUM_PORTS-1:0] pick_winner(input logic [NUM_PORTS-1:0] m,
                                                         input logic [2*NUM_PORTS-1:0] p);
        logic [NUM_PORTS-1:0] sel;
        logic [1:0]           best;
        logic                 found;
        sel   = '0;
        best  = 2'd0;
        found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (m[i] && (!found || (p[2*i +: 2] >= best))) begin
                sel    = '0;
                sel[i] = 1'b1;
                best   = p[2*i +: 2];
                found  = 1'b1;
            end
        end
        return sel;
    endfunction

    logic [NUM_PORTS-1:0] on_r;
    logic [UW-1:0]        pwr_used_r;
    logic [GW-1:0]        gap_r;
    state_t               state_r;

    logic [NUM_PORTS-1:0] drop_s;
    logic [NUM_PORTS-1:0] base_s;
    logic [NUM_PORTS-1:0] cand_s;
    logic [NUM_PORTS-1:0] winner_s;
    logic [NUM_PORTS-1:0] victim_s;
    logic [UW-1:0]        used_base_s;
    logic                 over_s;
    logic                 fits_s;
    logic                 grant_s;
    logic [GW-1:0]        gap_dec_s;
    logic [NUM_PORTS-1:0] on_nxt_s;
    logic [GW-1:0]        gap_nxt_s;
    state_t               state_nxt_s;

    // Next-state evaluation: ports_off > drop > shed > grant.
    always_comb begin
        drop_s      = on_r & (off | ~det);
        base_s      = on_r & ~drop_s;
        used_base_s = port_power(base_s);
        over_s      = (used_base_s > UW'(pwr_bdj));
        cand_s      = det & ~off & ~on_r;
        winner_s    = pick_winner(cand_s, prio);
        victim_s    = pick_victim(base_s, prio);
        fits_s      = ((UX'(used_base_s) + UX'(PWR_UNIT)) <= UX'(pwr_bdj));
        grant_s     = (gap_r == '0) && (cand_s != '0) && fits_s && !over_s;
        gap_dec_s   = (gap_r != '0) ? (gap_r - GW'(1)) : '0;

        on_nxt_s    = base_s;
        gap_nxt_s   = gap_dec_s;
        state_nxt_s = state_r;

        if (ports_off) begin
            on_nxt_s    = '0;
            gap_nxt_s   = '0;
            state_nxt_s = ST_IDLE;
        end else if (over_s) begin
            on_nxt_s    = base_s & ~victim_s;
            state_nxt_s = ST_SHED;
        end else if (grant_s) begin
            on_nxt_s    = base_s | winner_s;
            gap_nxt_s   = GAP_LOAD;
            state_nxt_s = ST_SETTLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_nxt_s = ST_IDLE;
                ST_SETTLE: state_nxt_s = (gap_dec_s == '0) ? ST_IDLE : ST_SETTLE;
                ST_SHED:   state_nxt_s = ST_IDLE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, gap counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            on_r       <= '0;
            pwr_used_r <= '0;
            gap_r      <= '0;
            state_r    <= ST_IDLE;
        end else begin
            on_r       <= on_nxt_s;
            pwr_used_r <= port_power(on_nxt_s);
            gap_r      <= gap_nxt_s;
            state_r    <= state_nxt_s;
        end
    end

    assign on       = on_r;
    assign pwr_used = pwr_used_r;

endmodule

// File: tb/tb_pds_power_manager.sv
// Directed scoreboard bench for pds_power_manager (NUM_PORTS=4, PORT_PWR=15, ON_GAP=4).
module tb_pds_power_manager;

    logic        clk;
    logic        rst;
    logic [3:0]  det;
    logic [3:0]  off;
    logic [7:0]  prio;
    logic [7:0]  pwr_bdj;
    logic        ports_off;
    logic [3:0]  on;
    logic [10:0] pwr_used;

    int vectors;
    int miscompares;
    logic [3:0] exp_q[$];

    pds_power_manager #(.NUM_PORTS(4), .PORT_PWR(15), .ON_GAP(4)) dut (
        .clk(clk), .rst(rst), .det(det), .off(off), .prio(prio),
        .pwr_bdj(pwr_bdj), .ports_off(ports_off), .on(on), .pwr_used(pwr_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] exp_power(input logic [3:0] v);
        return 11'(v[0]) * 11'd15 + 11'(v[1]) * 11'd15 + 11'(v[2]) * 11'd15 + 11'(v[3]) * 11'd15;
    endfunction

    // Push the expected on vector for the coming edge, then return at the following negedge.
    task automatic tick(input logic [3:0] eon);
        exp_q.push_back(eon);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: one registered output per edge, compared against the queued expectation.
    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (on !== e) begin
                miscompares++;
                $display("FAIL on vector %0d: got %b expected %b", vectors, on, e);
            end
            if (pwr_used !== exp_power(e)) begin
                miscompares++;
                $display("FAIL pwr_used vector %0d: got %0d expected %0d", vectors, pwr_used, exp_power(e));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; det = 4'hF; off = 4'h0; prio = 8'h00; pwr_bdj = 8'd60; ports_off = 1'b0;
        @(negedge clk);

        // Reset held for two edges with detect present.
        tick(4'b0000);
        tick(4'b0000);
        rst = 1'b0;

        // Staggered power-up, equal priorities: ports 0..3 at 4-edge spacing.
        for (int k = 0; k < 16; k++) begin
            tick((k < 4) ? 4'b0001 : (k < 8) ? 4'b0011 : (k < 12) ? 4'b0111 : 4'b1111);
        end

        // Budget drop 60->30: shed highest index one per edge, then settle.
        pwr_bdj = 8'd30;
        tick(4'b0111);
        tick(4'b0011);
        tick(4'b0011);

        // Drop port1 by losing detect; freed power grants port2 at exactly the budget.
        det = 4'b0111;
        tick(4'b0011);
        det = 4'b0101;
        tick(4'b0101);

        // Restore; gap still running, then port1 and port3 fill in.
        det = 4'hF; pwr_bdj = 8'd60;
        tick(4'b0101); tick(4'b0101); tick(4'b0101);
        tick(4'b0111); tick(4'b0111); tick(4'b0111); tick(4'b0111);
        tick(4'b1111);

        // Global kill for three edges, then immediate re-grant and a fresh gap.
        ports_off = 1'b1;
        tick(4'b0000); tick(4'b0000); tick(4'b0000);
        ports_off = 1'b0;
        tick(4'b0001); tick(4'b0001); tick(4'b0001); tick(4'b0001);
        tick(4'b0011);

        // Reset mid-sequence, then strict priority with budget 40.
        rst = 1'b1;
        tick(4'b0000);
        rst = 1'b0; prio = 8'b11_10_01_00; pwr_bdj = 8'd40;
        tick(4'b1000); tick(4'b1000); tick(4'b1000); tick(4'b1000);
        for (int k = 0; k < 8; k++) tick(4'b1100);

        // Force port2 off: dropped, port1 then fits (no bypass past a blocked winner before).
        off = 4'b0100;
        tick(4'b1010);
        off = 4'b0000;
        tick(4'b1010);

        // Budget 20: shed lowest-priority port1; port2 is the winner but does not fit.
        pwr_bdj = 8'd20;
        tick(4'b1000);
        for (int k = 0; k < 5; k++) tick(4'b1000);

        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
